// File: rtl/c16_pkg.sv
// Shared C16 top-level definitions: reset sequencer state encoding and source indices.
package c16_pkg;

  typedef enum logic [1:0] {
    RSQ_ASSERT  = 2'd0,
    RSQ_STAGGER = 2'd1,
    RSQ_RUN     = 2'd2
  } rsq_state_e;

  localparam int RSQ_SRC_COLD = 0;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int rsq_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/c16_reset_seq_debounce.sv
// Request filter: 2-flop synchroniser plus a stable-level debouncer.
// Only instantiated when RESET_SEQ_DEBOUNCE_EN is defined.
module req_debounce #(
  parameter int DEB_W = 16
) (
  input  logic CLK28,
  input  logic RESET_N,
  input  logic din,
  output logic dout
);

  // The level must differ from dout for 2^DEB_W-1 consecutive edges before it is taken.
  localparam logic [DEB_W-1:0] DEB_LAST = ~DEB_W'(1);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge CLK28) begin
    if (!RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/c16_reset_seq.sv
// Multi-source reset sequencer: cold/warm hold, then staggered release of RST_OUT[0..N_OUT-1].
// Optional request filtering is enabled by defining RESET_SEQ_DEBOUNCE_EN.
//
//   state       | meaning
//   ------------+--------------------------------------------------
//   RSQ_ASSERT  | all outputs in reset, hold counter runs to TERM
//   RSQ_STAGGER | outputs released one by one, STAGE_GAP apart
//   RSQ_RUN     | all outputs released, waiting for a request
module c16_reset_seq
  import c16_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int WARM_CYCLES = 65535,
  parameter int N_SRC       = 2,
  parameter int N_OUT       = 3,
  parameter int STAGE_GAP   = 16,
  parameter int DEB_W       = 16
) (
  input  logic             CLK28,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] REQ,
  input  logic             HOLD,
  output logic [N_OUT-1:0] RST_OUT,
  output logic             BUSY,
  output logic             COLD,
  output logic             DONE
);

  localparam int GAP_W = rsq_idx_w(STAGE_GAP);
  localparam int IDX_W = rsq_idx_w(N_OUT);

  localparam logic [CNT_W-1:0] WARM_TERM = CNT_W'(WARM_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);

  logic [N_SRC-1:0] req_f;

`ifdef RESET_SEQ_DEBOUNCE_EN
  for (genvar i = 0; i < N_SRC; i++) begin : g_deb
    req_debounce #(.DEB_W(DEB_W)) u_deb (
      .CLK28   (CLK28),
      .RESET_N (RESET_N),
      .din     (REQ[i]),
      .dout    (req_f[i])
    );
  end
`else
  assign req_f = REQ;
`endif

  rsq_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] hold_q, hold_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic [N_OUT-1:0] rst_q, rst_nxt;
  logic             cold_q, cold_nxt;
  logic             done_q, done_nxt;

  logic             req_cold;
  logic             req_warm;
  logic [CNT_W-1:0] term;

  assign req_cold = req_f[RSQ_SRC_COLD];
  assign req_warm = |(req_f >> 1);
  assign term     = cold_q ? '1 : WARM_TERM;

  always_comb begin
    state_nxt = state_q;
    hold_nxt  = hold_q;
    gap_nxt   = gap_q;
    idx_nxt   = idx_q;
    rst_nxt   = rst_q;
    cold_nxt  = cold_q;
    done_nxt  = 1'b0;

    if (req_cold || req_warm || HOLD) begin
      state_nxt = RSQ_ASSERT;
      hold_nxt  = '0;
      gap_nxt   = '0;
      idx_nxt   = '0;
      rst_nxt   = '1;
      // A cold sequence stays cold until it has reached RUN.
      if (req_cold)
        cold_nxt = 1'b1;
      else if (req_warm && !(cold_q && state_q != RSQ_RUN))
        cold_nxt = 1'b0;
    end else begin
      unique case (state_q)
        RSQ_ASSERT: begin
          if (hold_q == term) begin
            gap_nxt = '0;
            if (N_OUT == 1) begin
              state_nxt = RSQ_RUN;
              rst_nxt   = '0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt  = RSQ_STAGGER;
              rst_nxt[0] = 1'b0;
              idx_nxt    = IDX_W'(1);
            end
          end else begin
            hold_nxt = hold_q + CNT_W'(1);
          end
        end
        RSQ_STAGGER: begin
          if (gap_q == GAP_LAST) begin
            gap_nxt        = '0;
            rst_nxt[idx_q] = 1'b0;
            idx_nxt        = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_nxt = RSQ_RUN;
              done_nxt  = 1'b1;
            end
          end else begin
            gap_nxt = gap_q + GAP_W'(1);
          end
        end
        RSQ_RUN: ;
        default: begin
          state_nxt = RSQ_ASSERT;
          hold_nxt  = '0;
          gap_nxt   = '0;
          idx_nxt   = '0;
          rst_nxt   = '1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK28) begin
    if (!RESET_N) begin
      state_q <= RSQ_ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      cold_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      hold_q  <= hold_nxt;
      gap_q   <= gap_nxt;
      idx_q   <= idx_nxt;
      rst_q   <= rst_nxt;
      cold_q  <= cold_nxt;
      done_q  <= done_nxt;
    end
  end

  assign RST_OUT = rst_q;
  assign BUSY    = (state_q != RSQ_RUN);
  assign COLD    = cold_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_c16_reset_seq.sv
// Directed bench for c16_reset_seq with small parameters (cold TERM 15, warm TERM 5, gap 3).
// With RESET_SEQ_DEBOUNCE_EN defined it runs power-on plus the debounce scenarios.
module tb_c16_reset_seq;

  logic       CLK28 = 1'b0;
  logic       RESET_N;
  logic [1:0] REQ;
  logic       HOLD;
  logic [2:0] RST_OUT;
  logic       BUSY;
  logic       COLD;
  logic       DONE;

  int n_chk  = 0;
  int n_pass = 0;

  c16_reset_seq #(
    .CNT_W       (4),
    .WARM_CYCLES (5),
    .N_SRC       (2),
    .N_OUT       (3),
    .STAGE_GAP   (3),
    .DEB_W       (3)
  ) dut (
    .CLK28   (CLK28),
    .RESET_N (RESET_N),
    .REQ     (REQ),
    .HOLD    (HOLD),
    .RST_OUT (RST_OUT),
    .BUSY    (BUSY),
    .COLD    (COLD),
    .DONE    (DONE)
  );

  always #5 CLK28 = ~CLK28;

  task automatic step();
    @(posedge CLK28);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called with inputs idle and the next edge being request-free edge 1 of a hold of length term.
  // Expected: bit0 falls at edge term+1, bit1 at term+4, bit2 with DONE at term+7.
  task automatic release_check(input int term, input string tag);
    steps(term);
    chk({tag, "_hold_rst"}, RST_OUT, 3'b111);
    chk({tag, "_hold_busy"}, BUSY, 1'b1);
    step();
    chk({tag, "_b0_rst"}, RST_OUT, 3'b110);
    chk({tag, "_b0_done"}, DONE, 1'b0);
    steps(2);
    chk({tag, "_gap0_rst"}, RST_OUT, 3'b110);
    step();
    chk({tag, "_b1_rst"}, RST_OUT, 3'b100);
    steps(2);
    chk({tag, "_gap1_rst"}, RST_OUT, 3'b100);
    chk({tag, "_gap1_done"}, DONE, 1'b0);
    step();
    chk({tag, "_b2_rst"}, RST_OUT, 3'b000);
    chk({tag, "_b2_done"}, DONE, 1'b1);
    chk({tag, "_b2_busy"}, BUSY, 1'b0);
    step();
    chk({tag, "_run_done"}, DONE, 1'b0);
    chk({tag, "_run_rst"}, RST_OUT, 3'b000);
  endtask

  initial begin
    RESET_N = 1'b0;
    REQ     = 2'b00;
    HOLD    = 1'b0;

    // Power-on reset: two low edges, then cold sequence.
    steps(2);
    chk("por_rst", RST_OUT, 3'b111);
    chk("por_cold", COLD, 1'b1);
    chk("por_busy", BUSY, 1'b1);
    chk("por_done", DONE, 1'b0);
    RESET_N = 1'b1;
    release_check(15, "por");
    chk("por_cold_after", COLD, 1'b1);

`ifdef RESET_SEQ_DEBOUNCE_EN
    // 4-cycle glitch on REQ[1] must be filtered out.
    REQ = 2'b10;
    steps(4);
    REQ = 2'b00;
    steps(12);
    chk("glitch_rst", RST_OUT, 3'b000);
    chk("glitch_busy", BUSY, 1'b0);

    // 12-cycle pulse: reset asserts on edge 10 after REQ rises.
    REQ = 2'b10;
    steps(9);
    chk("deb_edge9_rst", RST_OUT, 3'b000);
    step();
    chk("deb_edge10_rst", RST_OUT, 3'b111);
    chk("deb_edge10_cold", COLD, 1'b0);
    steps(2);
    REQ = 2'b00;
    // Filtered request drops after edge 21; edge 22 is the first request-free edge.
    steps(9);
    release_check(5, "deb_warm");
`else
    // Warm reset from RUN.
    REQ = 2'b10;
    step();
    chk("warm_rst", RST_OUT, 3'b111);
    chk("warm_cold", COLD, 1'b0);
    chk("warm_busy", BUSY, 1'b1);
    REQ = 2'b00;
    release_check(5, "warm");

    // Cold priority: warm request during cold ASSERT keeps COLD and TERM=15.
    REQ = 2'b01;
    step();
    chk("prio_cold_set", COLD, 1'b1);
    REQ = 2'b00;
    steps(3);
    REQ = 2'b10;
    step();
    chk("prio_cold_kept", COLD, 1'b1);
    chk("prio_rst", RST_OUT, 3'b111);
    REQ = 2'b00;
    release_check(15, "prio");

    // HOLD from RUN after a cold sequence does not change COLD.
    HOLD = 1'b1;
    step();
    chk("hold_run_rst", RST_OUT, 3'b111);
    chk("hold_run_cold", COLD, 1'b1);
    HOLD = 1'b0;
    release_check(15, "hold_cold");

    // HOLD for 100 edges in the middle of a warm STAGGER.
    REQ = 2'b10;
    step();
    REQ = 2'b00;
    steps(6);
    chk("hold_pre_rst", RST_OUT, 3'b110);
    step();
    HOLD = 1'b1;
    step();
    chk("hold_first_rst", RST_OUT, 3'b111);
    chk("hold_first_cold", COLD, 1'b0);
    steps(99);
    chk("hold_last_rst", RST_OUT, 3'b111);
    chk("hold_last_busy", BUSY, 1'b1);
    chk("hold_last_cold", COLD, 1'b0);
    HOLD = 1'b0;
    release_check(5, "hold_warm");

    // Request on the edge where bit 0 would fall: nothing is released.
    REQ = 2'b10;
    step();
    REQ = 2'b00;
    steps(5);
    chk("conf_pre_rst", RST_OUT, 3'b111);
    REQ = 2'b10;
    step();
    chk("conf_rst", RST_OUT, 3'b111);
    chk("conf_done", DONE, 1'b0);
    chk("conf_cold", COLD, 1'b0);
    REQ = 2'b00;
    release_check(5, "conf");

    // RESET_N from RUN restarts a cold sequence.
    RESET_N = 1'b0;
    step();
    chk("rstn_rst", RST_OUT, 3'b111);
    chk("rstn_cold", COLD, 1'b1);
    RESET_N = 1'b1;
    release_check(15, "rstn");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
